// File: rtl/divider_seq.sv
// divider_seq: iterative restoring divider, one quotient bit per cycle.
//
// Divides WIDTH-bit operands in either unsigned or two's-complement mode,
// selected per operation. Quotient truncates toward zero, and the remainder
// takes the sign of the dividend. A zero divisor gives quotient = all ones and
// remainder = dividend after one cycle. Signed most-negative / -1 gives
// quotient = most-negative and remainder = 0. This comes from the magnitude
// algorithm itself; there is no special path for it.
//
// Ports:
//   clk, sync_rst          clock and synchronous active-high reset
//   in_valid / in_ready    operand handshake
//   signed_mode            1 = signed divide, 0 = unsigned (sampled on accept)
//   dividend, divisor      operands (sampled on accept)
//   out_valid / out_ready  result handshake; results held until taken
//   quotient, remainder    result registers; they hold the last result in idle
//
// Optional build macro DIVIDER_SEQ_STATUS_EN adds the outputs div_by_zero and
// overflow. Both are valid together with out_valid.
`timescale 1ns/1ps
module divider_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVIDER_SEQ_STATUS_EN
  ,
  output logic             div_by_zero,
  output logic             overflow
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;      // partial remainder; always < divisor magnitude
  logic [WIDTH-1:0] quo_q;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic             neg_quo_q;
  logic             neg_rem_q;

  // Shifted partial remainder is WIDTH+1 bits, so the trial subtract keeps its borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic             accept;

  always_comb begin
    shifted      = {rem_q, quo_q[WIDTH-1]};
    diff         = shifted - {1'b0, dvs_q};
    // Negating the most-negative value leaves its bit pattern unchanged.
    // Read as unsigned, that pattern is already the magnitude 2^(WIDTH-1).
    dividend_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_mag  = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;
    accept       = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            neg_quo_q <= signed_mode && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q <= signed_mode && dividend[WIDTH-1];
            quo_q     <= dividend_mag;
            dvs_q     <= divisor_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (diff[WIDTH]) begin
            // Borrow: the trial subtract went negative, so restore.
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          quotient  <= neg_quo_q ? -quo_q : quo_q;
          remainder <= neg_rem_q ? -rem_q : rem_q;
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef DIVIDER_SEQ_STATUS_EN
  logic ovf_pend_q;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      ovf_pend_q  <= 1'b0;
    end else if (state_q == StIdle && accept) begin
      ovf_pend_q <= signed_mode && (dividend == {1'b1, {(WIDTH - 1){1'b0}}}) && (&divisor);
      if (divisor == '0) begin
        div_by_zero <= 1'b1;
        overflow    <= 1'b0;
      end
    end else if (state_q == StFix) begin
      div_by_zero <= 1'b0;
      overflow    <= ovf_pend_q;
    end
  end
`endif

endmodule

// File: tb/tb_divider_seq.sv
`timescale 1ns/1ps
module tb_divider_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         sync_rst;
  logic         in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         dz, ov;

  // Second instance at WIDTH=8 for the narrow-width checks.
  logic         b_in_valid, b_in_ready, b_signed_mode, b_out_valid, b_out_ready;
  logic [7:0]   b_dividend, b_divisor, b_quotient, b_remainder;
  logic         b_dz, b_ov;

  always #5 clk = ~clk;

  divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .sync_rst(sync_rst), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient), .remainder(remainder)
`ifdef DIVIDER_SEQ_STATUS_EN
    , .div_by_zero(dz), .overflow(ov)
`endif
  );

  divider_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .sync_rst(sync_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .signed_mode(b_signed_mode), .dividend(b_dividend), .divisor(b_divisor),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .quotient(b_quotient),
    .remainder(b_remainder)
`ifdef DIVIDER_SEQ_STATUS_EN
    , .div_by_zero(b_dz), .overflow(b_ov)
`endif
  );

`ifndef DIVIDER_SEQ_STATUS_EN
  assign dz = 1'b0;
  assign ov = 1'b0;
  assign b_dz = 1'b0;
  assign b_ov = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference: plain integer division, truncating toward zero.
  function automatic exp_t model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sd;
    e.dz = (b == '0);
    e.ov = 1'b0;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else if (sm) begin
      sa   = longint'($signed(a));
      sd   = longint'($signed(b));
      e.q  = W'(sa / sd);
      e.r  = W'(sa % sd);
      e.ov = (sa == -(longint'(1) <<< (W - 1))) && (sd == -1);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: compare each result as it is taken.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!sync_rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: result 0x%0h/0x%0h with no expectation", quotient,
                 remainder);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", {32'd0, quotient}, {32'd0, mon_e.q});
        chk("remainder", {32'd0, remainder}, {32'd0, mon_e.r});
`ifdef DIVIDER_SEQ_STATUS_EN
        chk("div_by_zero", {63'd0, dz}, {63'd0, mon_e.dz});
        chk("overflow", {63'd0, ov}, {63'd0, mon_e.ov});
`endif
      end
    end
  end

  // Call at a negedge. Issue one op with out_ready=1 and check latency and the turnaround.
  task automatic run_div(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    bit seen;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      timeout("in_ready");
      return;
    end
    in_valid = 1'b1; signed_mode = sm; dividend = a; divisor = b;
    sb.push_back(model(sm, a, b));
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    if (!seen) begin
      timeout("out_valid");
      return;
    end
    chk("latency", 64'(lat), (b == '0) ? 64'd1 : 64'(W + 2));
    @(negedge clk);
    chk("in_ready_after_take", {63'd0, in_ready}, 64'd1);
    chk("out_valid_after_take", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input int elat);
    int lat;
    bit seen;
    for (int i = 0; i < 50 && !b_in_ready; i++) @(negedge clk);
    b_in_valid = 1'b1; b_signed_mode = sm; b_dividend = a; b_divisor = b;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_out_valid) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    if (!seen) begin
      timeout("w8_out_valid");
      return;
    end
    chk("w8_latency", 64'(lat), 64'(elat));
    chk("w8_quotient", {56'd0, b_quotient}, {56'd0, eq});
    chk("w8_remainder", {56'd0, b_remainder}, {56'd0, er});
    @(negedge clk);
  endtask

  initial begin
    exp_t         e;
    logic [W-1:0] ra, rb;
    int           hits;
    bit           seen;
    sync_rst = 1'b1; in_valid = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    out_ready = 1'b1;
    b_in_valid = 1'b0; b_signed_mode = 1'b0; b_dividend = '0; b_divisor = '0;
    b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 sync_rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_quotient", {32'd0, quotient}, 64'd0);
    chk("rst_remainder", {32'd0, remainder}, 64'd0);
`ifdef DIVIDER_SEQ_STATUS_EN
    chk("rst_flags", {62'd0, dz, ov}, 64'd0);
`endif

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7);
    run_div(1'b1, -32'sd7, 32'd2);
    run_div(1'b1, 32'd7, -32'sd2);
    run_div(1'b0, 32'h1234_5678, 32'd0);
    run_div(1'b1, 32'h1234_5678, 32'd0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(1'b1, 32'hF000_0000, 32'd0);

    // Backpressure: hold the result for 5 cycles while a second op waits on in_valid
    out_ready = 1'b0;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1; signed_mode = 1'b0; dividend = 32'd1000; divisor = 32'd33;
    e = model(1'b0, 32'd1000, 32'd33);
    sb.push_back(e);
    @(posedge clk);
    #1 dividend = 32'd55; divisor = 32'd5;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("bp_out_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_quotient", {32'd0, quotient}, {32'd0, e.q});
      chk("bp_remainder", {32'd0, remainder}, {32'd0, e.r});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_accept_on_take", {63'd0, in_ready}, 64'd1);

    // Randomized
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(1'($urandom_range(0, 1)), ra, rb);
    end

    // Reset in the middle of CALC: the op is aborted and produces no result
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1; signed_mode = 1'b0; dividend = 32'd999; divisor = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 sync_rst = 1'b1;
    @(posedge clk);
    #1 sync_rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_quotient", {32'd0, quotient}, 64'd0);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("abort_no_result", 64'(hits), 64'd0);

    // WIDTH=8 instance
    run8(1'b0, 8'd200, 8'd13, 8'd15, 8'd5, 10);
    run8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 10);
    run8(1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 10);
    run8(1'b0, 8'hA5, 8'h00, 8'hFF, 8'hA5, 1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
